// File: rtl/timer_apb_regs_if.sv
// APB3 bus bundle between the system bus master and the timer register bank.
interface timer_apb_regs_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/timer_apb_regs.sv
// APB3 register bank that programs the timer and turns its terminal-count level into a
// sticky, maskable, level interrupt with a saturating event counter.
module timer_apb_regs #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned IRQCNT_W = 16
) (
  input  logic            CLK,
  input  logic            RSTN,
  timer_apb_regs_if.slave apb,
  output logic            MODE,
  output logic            GO_EN,
  output logic [31:0]     TOT_CNT,
  output logic [31:0]     DUTY_CNT,
  input  logic            IRQ_TRG,
  input  logic            PWM,
  output logic            IRQ
);

  // The setup phase is the StIdle cycle in which PSEL & ~PENABLE is seen; StWait is the first
  // access cycle (PREADY low) and StDone presents the registered response.
  typedef enum logic [1:0] {StIdle, StWait, StDone} apb_state_e;

  localparam logic [2:0] OffCtrl   = 3'd0;
  localparam logic [2:0] OffTot    = 3'd1;
  localparam logic [2:0] OffDuty   = 3'd2;
  localparam logic [2:0] OffStat   = 3'd3;
  localparam logic [2:0] OffInten  = 3'd4;
  localparam logic [2:0] OffIrqcnt = 3'd5;

  apb_state_e          state_q;
  logic                pready_q, pslverr_q;
  logic [31:0]         prdata_q;

  logic                go_en_q, go_en_d;
  logic                mode_q, mode_d;
  logic                auto_stop_q, auto_stop_d;
  logic [31:0]         tot_q, tot_d;
  logic [31:0]         duty_q, duty_d;
  logic                pend_q, pend_d;
  logic                en_q, en_d;
  logic [IRQCNT_W-1:0] irqcnt_q, irqcnt_d, irqcnt_base;
  logic                irq_q, irq_d;
  logic                trg_q;

  logic [ADDR_W-1:0]   paddr;
  logic [2:0]          off;
  logic                mapped, access, err, do_wr, event_hit, hw_stop;
  logic [31:0]         rdata;

  assign paddr = apb.PADDR;
  assign off   = paddr[4:2];

  // Address decode, error classification and read mux for the current access cycle.
  always_comb begin
    mapped = ((paddr >> 5) == '0) && (off <= OffIrqcnt);
    access = (state_q == StWait) && apb.PSEL && apb.PENABLE;
    // Period/duty must not change under a running timer.
    err    = !mapped || (apb.PWRITE && go_en_q && ((off == OffTot) || (off == OffDuty)));
    do_wr  = access && apb.PWRITE && !err;
    rdata  = '0;
    case (off)
      OffCtrl:   rdata = {29'd0, auto_stop_q, mode_q, go_en_q};
      OffTot:    rdata = tot_q;
      OffDuty:   rdata = duty_q;
      OffStat:   rdata = {30'd0, PWM, pend_q};
      OffInten:  rdata = {31'd0, en_q};
      OffIrqcnt: rdata = 32'(irqcnt_q);
      default:   rdata = '0;
    endcase
  end

  // Next-state of the register bank: software writes first, then hardware events override.
  always_comb begin
    go_en_d     = go_en_q;
    mode_d      = mode_q;
    auto_stop_d = auto_stop_q;
    tot_d       = tot_q;
    duty_d      = duty_q;
    pend_d      = pend_q;
    en_d        = en_q;
    irqcnt_base = irqcnt_q;
    event_hit   = IRQ_TRG && !trg_q;
    hw_stop     = event_hit && auto_stop_q && !mode_q;
    if (do_wr) begin
      case (off)
        OffCtrl: begin
          go_en_d     = apb.PWDATA[0];
          mode_d      = apb.PWDATA[1];
          auto_stop_d = apb.PWDATA[2];
        end
        OffTot:    tot_d  = apb.PWDATA;
        OffDuty:   duty_d = apb.PWDATA;
        OffStat:   if (apb.PWDATA[0]) pend_d = 1'b0;
        OffInten:  en_d = apb.PWDATA[0];
        OffIrqcnt: irqcnt_base = '0;
        default:   ;
      endcase
    end
    irqcnt_d = irqcnt_base;
    if (event_hit) begin
      pend_d   = 1'b1;
      irqcnt_d = (&irqcnt_base) ? irqcnt_base : irqcnt_base + IRQCNT_W'(1);
    end
    if (hw_stop) go_en_d = 1'b0;
    irq_d = pend_q && en_q;
  end

  // APB transfer FSM with registered PREADY/PSLVERR/PRDATA.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= StIdle;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (apb.PSEL && !apb.PENABLE) state_q <= StWait;
        end
        StWait: begin
          if (apb.PSEL && apb.PENABLE) begin
            state_q   <= StDone;
            pready_q  <= 1'b1;
            pslverr_q <= err;
            prdata_q  <= (err || apb.PWRITE) ? '0 : rdata;
          end else if (!apb.PSEL) begin
            state_q <= StIdle;
          end
        end
        StDone: begin
          state_q   <= StIdle;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Register bank, trigger edge flop and registered interrupt.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      go_en_q     <= 1'b0;
      mode_q      <= 1'b0;
      auto_stop_q <= 1'b0;
      tot_q       <= '0;
      duty_q      <= '0;
      pend_q      <= 1'b0;
      en_q        <= 1'b0;
      irqcnt_q    <= '0;
      irq_q       <= 1'b0;
      trg_q       <= 1'b0;
    end else begin
      go_en_q     <= go_en_d;
      mode_q      <= mode_d;
      auto_stop_q <= auto_stop_d;
      tot_q       <= tot_d;
      duty_q      <= duty_d;
      pend_q      <= pend_d;
      en_q        <= en_d;
      irqcnt_q    <= irqcnt_d;
      irq_q       <= irq_d;
      trg_q       <= IRQ_TRG;
    end
  end

  assign apb.PRDATA  = prdata_q;
  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;
  assign GO_EN       = go_en_q;
  assign MODE        = mode_q;
  assign TOT_CNT     = tot_q;
  assign DUTY_CNT    = duty_q;
  assign IRQ         = irq_q;

endmodule
